alu_mem_core: RTL and testbench
===============================

# alu_mem_core

Memory-backed two-operand ALU: on `start` it reads two 16-bit operands from an internal word-addressed memory at two caller-supplied addresses on consecutive cycles. It then writes the add or multiply result back to a third address. It sits behind a simple start/ready command interface and exposes its memory bus and last result for observation and formal checking.

## Interface
- `ASIZE`, 20, memory address width (depth 2^ASIZE words)
- `DSIZE`, 16, data word width
- `clk` in 1, single clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `start` in 1, command request; accepted only when `ready`=1
- `opcode` in 8, 0x05 = ADD, 0x06 = MUL; sampled on accept
- `addr` in ASIZE, per-phase address: op1 on the accept cycle, op2 on the next cycle, result on the one after
- `ld_we` in 1, preload write strobe (test/init path)
- `ld_addr` in ASIZE, preload address
- `ld_data` in DSIZE, preload data
- `ready` out 1, high in IDLE
- `mem_we` out 1, internal memory write enable
- `mem_addr` out ASIZE, internal memory address
- `mem_wdata` out DSIZE, internal memory write data
- `mem_rdata` out DSIZE, internal memory read data (combinational, mem[mem_addr])
- `res_data` out DSIZE, last ALU result written to memory

## Operation
- FSM states: IDLE → OP2 → RES → IDLE.
- IDLE:
  - `ready`=1; `mem_addr`=`addr`.
  - On `start`: latch op1=`mem_rdata`, latch opcode, go to OP2.
  - Without `start`: if `ld_we`=1, write `ld_data` to `ld_addr`; `mem_addr`=`ld_addr` that cycle.
  - `start` has priority over `ld_we`; `ld_we` is ignored outside IDLE.
- OP2: `ready`=0; `mem_addr`=`addr`; latch op2=`mem_rdata`; go to RES.
- RES:
  - `ready`=0; `mem_addr`=`addr`.
  - `mem_wdata`=result, `mem_we`=1 for a valid opcode.
  - At the clock edge, mem[`addr`]←result and `res_data`←result; return to IDLE.
- Arithmetic:
  - ADD = (op1+op2) mod 2^DSIZE.
  - MUL = low DSIZE bits of op1×op2.
- Invalid opcode: the sequence still takes 3 cycles, but `mem_we`=0 in RES and `res_data` is unchanged.
- `start` while `ready`=0 is ignored, with no queueing.
- Memory read is asynchronous. Memory write is synchronous and occurs on the rising edge.
- Single memory port, so read/write collision is impossible.
- Memory contents are not reset.
- Illegal FSM encoding → IDLE.

## Timing
- Accept at cycle T; op1 is read at T, op2 at T+1, and the result is written at the end of T+2.
- `res_data` is valid from T+3 (i.e. ##3 after accept).
- `ready` is low during T+1 and T+2 and high again at T+3. Back-to-back commands are accepted every 3 cycles.
- A read at T+3 of the just-written address returns the new value.
- Same address for op1 and op2 is legal. A result address equal to an operand address overwrites it.
- Reset values, asynchronous on `rst_n`=0:
  - State=IDLE, `ready`=1.
  - op1, op2, `res_data` = 0.
  - `mem_we`=0; `mem_wdata`=0 outside RES.
- Reset mid-operation aborts without writing.

## Configuration
- `ALU_MUL_EN`:
  - Defined: opcode 0x06 performs MUL.
  - Undefined: no multiplier is built, and 0x06 is treated as an invalid opcode (no write).

## Structure
- Shared package `alu_mem_pkg`: state enum (IDLE=2'b00, OP2=2'b01, RES=2'b10), opcode constants OP_ADD=8'h05 and OP_MUL=8'h06.
- One sub-module `alu_mem_ram` (ASIZE/DSIZE parameterized, async read, sync write).
- FSM and datapath live in the top level.

## Test plan
- Preload mem[0x10]=0x0003, mem[0x20]=0x0004; ADD with addr sequence 0x10, 0x20, 0x30 → `res_data`=0x0007 at T+3, mem[0x30]=0x0007.
- Preload 0xFFFF and 0x0002; ADD → 0x0001 (wraparound).
- With `ALU_MUL_EN`: 0x0100 × 0x0101 → 0x0100 (low 16 bits); without the macro → no write, `res_data` unchanged.
- `start` pulsed at T+1 and T+2 during a busy period → ignored. A new command at T+3 is accepted, and an operand read at the prior result address returns the new value.
- Opcode 0x07 → `mem_we` stays 0 for 3 cycles, `ready` returns high at T+3.
- Assert `rst_n` low in OP2 → `ready`=1 and `res_data`=0 immediately, no memory write, preloaded data intact.

Source files
------------

// File: rtl/alu_mem_pkg.sv
// Shared definitions for the memory-backed two-operand ALU.
// Holds the FSM state encoding and the opcode constants.
package alu_mem_pkg;

    localparam int unsigned OPC_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OP2  = 2'b01,
        RES  = 2'b10
    } state_e;

    localparam logic [OPC_W-1:0] OP_ADD = 8'h05;
    localparam logic [OPC_W-1:0] OP_MUL = 8'h06;

endpackage

// File: rtl/alu_mem_ram.sv
// Single-port word memory: asynchronous read, synchronous write, no reset.
// Ports:
//   clk           - write clock, rising edge
//   we            - write enable
//   addr          - word address (shared by read and write)
//   wdata         - write data
//   rdata         - combinational read data, mem[addr]
module alu_mem_ram #(
    parameter int unsigned ASIZE = 20,
    parameter int unsigned DSIZE = 16
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] addr,
    input  logic [DSIZE-1:0] wdata,
    output logic [DSIZE-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/alu_mem_core.sv
// Memory-backed two-operand ALU behind a start/ready command interface.
// A command reads op1 (accept cycle) and op2 (next cycle) from the internal
// memory, then writes ADD or MUL of them to a third address.
// Optional feature macro: ALU_MUL_EN builds the multiplier for opcode 0x06;
// without it 0x06 is an invalid opcode and nothing is written.
// Ports:
//   clk, rst_n    - clock (rising edge), asynchronous active-low reset
//   start, opcode - command request (accepted when ready) and operation
//   addr          - op1 / op2 / result address on consecutive cycles
//   ld_we, ld_addr, ld_data - preload write path, honoured in IDLE only
//   ready         - high while idle
//   mem_we, mem_wdata - ALU result write strobe and data (RES cycle only)
//   mem_addr, mem_rdata - memory address bus and async read data
//   res_data      - last result written to memory
module alu_mem_core
    import alu_mem_pkg::*;
#(
    parameter int unsigned ASIZE = 20,
    parameter int unsigned DSIZE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       opcode,
    input  logic [ASIZE-1:0] addr,
    input  logic             ld_we,
    input  logic [ASIZE-1:0] ld_addr,
    input  logic [DSIZE-1:0] ld_data,
    output logic             ready,
    output logic             mem_we,
    output logic [ASIZE-1:0] mem_addr,
    output logic [DSIZE-1:0] mem_wdata,
    output logic [DSIZE-1:0] mem_rdata,
    output logic [DSIZE-1:0] res_data
);

    state_e           state_q, state_d;
    logic [7:0]       opcode_q;
    logic [DSIZE-1:0] op1_q, op2_q;
    logic [DSIZE-1:0] result;
    logic             op_valid;
    logic             ram_we;
    logic [DSIZE-1:0] ram_wdata;

    // Arithmetic: both results are truncated to DSIZE bits.
    logic [DSIZE-1:0] sum;
    assign sum = op1_q + op2_q;

`ifdef ALU_MUL_EN
    logic [DSIZE-1:0] mul_lo;
    assign mul_lo   = op1_q * op2_q;
    assign op_valid = (opcode_q == OP_ADD) || (opcode_q == OP_MUL);
    assign result   = (opcode_q == OP_MUL) ? mul_lo : sum;
`else
    assign op_valid = (opcode_q == OP_ADD);
    assign result   = sum;
`endif

    // Next-state and bus control; preload shares the single RAM port in IDLE.
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        mem_addr  = addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = OP2;
                end else if (ld_we) begin
                    mem_addr  = ld_addr;
                    ram_we    = 1'b1;
                    ram_wdata = ld_data;
                end
            end
            OP2: begin
                state_d = RES;
            end
            RES: begin
                state_d = IDLE;
                if (op_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = result;
                    ram_we    = 1'b1;
                    ram_wdata = result;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, opcode and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_q    <= '0;
            op2_q    <= '0;
            opcode_q <= '0;
            res_data <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                op1_q    <= mem_rdata;
                opcode_q <= opcode;
            end
            if (state_q == OP2) begin
                op2_q <= mem_rdata;
            end
            if (state_q == RES && op_valid) begin
                res_data <= result;
            end
        end
    end

    alu_mem_ram #(
        .ASIZE(ASIZE),
        .DSIZE(DSIZE)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (mem_addr),
        .wdata(ram_wdata),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_alu_mem_core.sv
// Directed self-checking bench for alu_mem_core.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_alu_mem_core;

    localparam int unsigned ASIZE = 20;
    localparam int unsigned DSIZE = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [7:0]       opcode;
    logic [ASIZE-1:0] addr;
    logic             ld_we;
    logic [ASIZE-1:0] ld_addr;
    logic [DSIZE-1:0] ld_data;
    logic             ready;
    logic             mem_we;
    logic [ASIZE-1:0] mem_addr;
    logic [DSIZE-1:0] mem_wdata;
    logic [DSIZE-1:0] mem_rdata;
    logic [DSIZE-1:0] res_data;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mem_core #(.ASIZE(ASIZE), .DSIZE(DSIZE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .opcode   (opcode),
        .addr     (addr),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ready    (ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .res_data (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge (input drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ASIZE-1:0] a, input logic [DSIZE-1:0] d);
        step();
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
        ld_we   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready got %b exp 1", ready);
        end
        n_checks++;
        if (res_data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_res_data got %h exp 0000", res_data);
        end
        n_checks++;
        if (mem_we !== 1'b0 || mem_wdata !== 16'h0000) begin
            n_fail++; $display("FAIL reset_mem_we got %b/%h exp 0/0000", mem_we, mem_wdata);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        preload(20'h10, 16'h0003);
        preload(20'h20, 16'h0004);
        // T: accept
        start = 1'b1; opcode = 8'h05; addr = 20'h10;
        #1;
        n_checks++;
        if (ready !== 1'b1 || mem_rdata !== 16'h0003) begin
            n_fail++; $display("FAIL add_accept got ready=%b rdata=%h exp 1/0003", ready, mem_rdata);
        end
        step(); // T+1
        start = 1'b0; addr = 20'h20;
        #1;
        n_checks++;
        if (ready !== 1'b0 || mem_rdata !== 16'h0004) begin
            n_fail++; $display("FAIL add_op2 got ready=%b rdata=%h exp 0/0004", ready, mem_rdata);
        end
        step(); // T+2
        addr = 20'h30;
        #1;
        n_checks++;
        if (ready !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 16'h0007 || mem_addr !== 20'h30) begin
            n_fail++; $display("FAIL add_res got ready=%b we=%b wdata=%h addr=%h exp 0/1/0007/00030",
                               ready, mem_we, mem_wdata, mem_addr);
        end
        step(); // T+3
        #1;
        n_checks++;
        if (ready !== 1'b1 || res_data !== 16'h0007 || mem_rdata !== 16'h0007) begin
            n_fail++; $display("FAIL add_result got ready=%b res=%h mem=%h exp 1/0007/0007",
                               ready, res_data, mem_rdata);
        end
    endtask

    task automatic test_wrap();
        preload(20'h40, 16'hFFFF);
        preload(20'h41, 16'h0002);
        start = 1'b1; opcode = 8'h05; addr = 20'h40;
        step(); start = 1'b0; addr = 20'h41;
        step(); addr = 20'h42;
        #1;
        n_checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 16'h0001) begin
            n_fail++; $display("FAIL wrap_res got we=%b wdata=%h exp 1/0001", mem_we, mem_wdata);
        end
        step();
        #1;
        n_checks++;
        if (res_data !== 16'h0001 || mem_rdata !== 16'h0001) begin
            n_fail++; $display("FAIL wrap_result got res=%h mem=%h exp 0001/0001", res_data, mem_rdata);
        end
    endtask

    task automatic test_mul();
        logic [DSIZE-1:0] exp_res;
        logic [DSIZE-1:0] exp_mem;
        logic             exp_we;
`ifdef ALU_MUL_EN
        exp_res = 16'h0100; exp_mem = 16'h0100; exp_we = 1'b1;
`else
        exp_res = 16'h0001; exp_mem = 16'hBEEF; exp_we = 1'b0;
`endif
        preload(20'h50, 16'h0100);
        preload(20'h51, 16'h0101);
        preload(20'h52, 16'hBEEF);
        start = 1'b1; opcode = 8'h06; addr = 20'h50;
        step(); start = 1'b0; addr = 20'h51;
        step(); addr = 20'h52;
        #1;
        n_checks++;
        if (mem_we !== exp_we) begin
            n_fail++; $display("FAIL mul_we got %b exp %b", mem_we, exp_we);
        end
        step();
        #1;
        n_checks++;
        if (res_data !== exp_res || mem_rdata !== exp_mem) begin
            n_fail++; $display("FAIL mul_result got res=%h mem=%h exp %h/%h",
                               res_data, mem_rdata, exp_res, exp_mem);
        end
    endtask

    task automatic test_back_to_back();
        preload(20'h60, 16'h0005);
        preload(20'h61, 16'h0006);
        preload(20'h64, 16'h0000);
        start = 1'b1; opcode = 8'h05; addr = 20'h60;
        step(); // T+1: busy, start held, preload attempted
        addr = 20'h61; opcode = 8'h07;
        ld_we = 1'b1; ld_addr = 20'h64; ld_data = 16'hDEAD;
        #1;
        n_checks++;
        if (ready !== 1'b0 || mem_addr !== 20'h61) begin
            n_fail++; $display("FAIL b2b_busy1 got ready=%b addr=%h exp 0/00061", ready, mem_addr);
        end
        step(); // T+2
        addr = 20'h62;
        #1;
        n_checks++;
        if (ready !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 16'h000B) begin
            n_fail++; $display("FAIL b2b_res got ready=%b we=%b wdata=%h exp 0/1/000B",
                               ready, mem_we, mem_wdata);
        end
        step(); // T+3: new command reads the just-written address
        ld_we = 1'b0; opcode = 8'h05; addr = 20'h62;
        #1;
        n_checks++;
        if (ready !== 1'b1 || res_data !== 16'h000B || mem_rdata !== 16'h000B) begin
            n_fail++; $display("FAIL b2b_accept got ready=%b res=%h rdata=%h exp 1/000B/000B",
                               ready, res_data, mem_rdata);
        end
        step(); start = 1'b0; addr = 20'h60;
        step(); addr = 20'h63;
        step();
        addr = 20'h64;
        #1;
        n_checks++;
        if (res_data !== 16'h0010 || ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second got res=%h ready=%b exp 0010/1", res_data, ready);
        end
        n_checks++;
        if (mem_rdata !== 16'h0000) begin
            n_fail++; $display("FAIL b2b_ld_ignored got mem[64]=%h exp 0000", mem_rdata);
        end
        addr = 20'h63;
        #1;
        n_checks++;
        if (mem_rdata !== 16'h0010) begin
            n_fail++; $display("FAIL b2b_mem63 got %h exp 0010", mem_rdata);
        end
    endtask

    task automatic test_invalid();
        int we_seen = 0;
        start = 1'b1; opcode = 8'h07; addr = 20'h10;
        #1;
        if (mem_we !== 1'b0) we_seen++;
        step(); start = 1'b0; addr = 20'h20;
        #1;
        if (mem_we !== 1'b0) we_seen++;
        step(); addr = 20'h30;
        #1;
        if (mem_we !== 1'b0) we_seen++;
        n_checks++;
        if (we_seen != 0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL inv_we got we_cycles=%0d ready=%b exp 0/0", we_seen, ready);
        end
        step();
        #1;
        n_checks++;
        if (ready !== 1'b1 || res_data !== 16'h0010 || mem_rdata !== 16'h0007) begin
            n_fail++; $display("FAIL inv_end got ready=%b res=%h mem30=%h exp 1/0010/0007",
                               ready, res_data, mem_rdata);
        end
    endtask

    task automatic test_reset_mid();
        preload(20'h70, 16'h1234);
        start = 1'b1; opcode = 8'h05; addr = 20'h10;
        step(); // OP2
        start = 1'b0; addr = 20'h20;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1 || res_data !== 16'h0000) begin
            n_fail++; $display("FAIL rstmid_now got ready=%b res=%h exp 1/0000", ready, res_data);
        end
        addr = 20'h70;
        step();
        step();
        rst_n = 1'b1;
        step();
        #1;
        n_checks++;
        if (mem_rdata !== 16'h1234 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_mem70 got %h we=%b exp 1234/0", mem_rdata, mem_we);
        end
        addr = 20'h10;
        #1;
        n_checks++;
        if (mem_rdata !== 16'h0003) begin
            n_fail++; $display("FAIL rstmid_mem10 got %h exp 0003", mem_rdata);
        end
    endtask

    initial begin
        start   = 1'b0;
        opcode  = 8'h00;
        addr    = '0;
        ld_we   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        rst_n   = 1'b1;
        test_reset();
        test_add();
        test_wrap();
        test_mul();
        test_back_to_back();
        test_invalid();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
